// File: rtl/dac_spi_pkg.sv
// Shared definitions for the DAC SPI serializer.
// Contents: FSM state encoding, frame/data widths, counter widths and the
// frame builder (two's-complement sample -> 16-bit DAC frame).
package dac_spi_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned DATA_BITS  = 12;
    localparam int unsigned BIT_CNT_W  = $clog2(FRAME_BITS);
    localparam int unsigned DIV_CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_e;

    // Frame: 2 don't-care zeros, power-down bits, offset-binary sample.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [1:0]           pd,
        input logic [DATA_BITS-1:0] sample
    );
        return {2'b00, pd, ~sample[DATA_BITS-1], sample[DATA_BITS-2:0]};
    endfunction

endpackage

// File: rtl/dac_spi_tick.sv
// Half-period tick generator for the DAC SPI serializer.
// Ports: clk, reset (async, active low), en_i (count enable; counter is held
// at zero while low), tick_c (one-cycle pulse every DIV_MED enabled cycles).
module dac_spi_tick
    import dac_spi_pkg::*;
#(
    parameter int unsigned DIV_MED = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic en_i,
    output logic tick_c
);

    localparam logic [DIV_CNT_W-1:0] LAST = DIV_CNT_W'(DIV_MED - 1);

    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;

    assign tick_c = en_i && (cnt_q == LAST);

    // Count 0..DIV_MED-1 while enabled, wrap on tick.
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || tick_c) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DIV_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dac_spi_tx.sv
// SPI serializer for a DAC121S101-class DAC: one 16-bit frame per accepted
// sample, MSB first, sclk idles high, DAC samples on the sclk falling edge.
// Ports: clk, reset (async, active low), start/dato (sample strobe and signed
// 12-bit sample), busy, done (one-cycle frame-complete pulse), sync_n, sclk,
// sdata. Optional macro DAC_SPI_BUF_EN adds a one-entry latest-wins buffer
// for samples arriving while busy.
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int unsigned DIV_MED = 2,
    parameter logic [1:0]  PD_MODE = 2'b00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] dato,
    output logic                 busy,
    output logic                 done,
    output logic                 sync_n,
    output logic                 sclk,
    output logic                 sdata
);

    state_e                 state_q, state_d;
    logic                   phase_q, phase_d;   // 0: sclk-high half, 1: sclk-low half
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0]  shreg_q, shreg_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   sync_n_q, sync_n_d;
    logic                   sclk_q, sclk_d;
    logic                   sdata_q, sdata_d;
    logic                   tick_c;
    logic                   launch_c;
    logic [DATA_BITS-1:0]   launch_data_c;
    logic [FRAME_BITS-1:0]  frame_c;
`ifdef DAC_SPI_BUF_EN
    logic [DATA_BITS-1:0]   buf_q, buf_d;
    logic                   buf_vld_q, buf_vld_d;
    logic                   gap_end_c;
`endif

    dac_spi_tick #(.DIV_MED(DIV_MED)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .en_i   (state_q != ST_IDLE),
        .tick_c (tick_c)
    );

    // Next-state and output logic.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        bit_cnt_d     = bit_cnt_q;
        shreg_d       = shreg_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        sync_n_d      = sync_n_q;
        sclk_d        = sclk_q;
        sdata_d       = sdata_q;
        launch_c      = 1'b0;
        launch_data_c = dato;
        frame_c       = '0;
`ifdef DAC_SPI_BUF_EN
        buf_d         = buf_q;
        buf_vld_d     = buf_vld_q;
        gap_end_c     = (state_q == ST_GAP) && tick_c && phase_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    launch_c = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (tick_c) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                        sclk_d  = 1'b0;
                    end else if (bit_cnt_q == '0) begin
                        state_d  = ST_GAP;
                        phase_d  = 1'b0;
                        sclk_d   = 1'b1;
                        sync_n_d = 1'b1;
                        sdata_d  = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        // Next bit appears at the start of the sclk-high half.
                        bit_cnt_d = bit_cnt_q - BIT_CNT_W'(1);
                        phase_d   = 1'b0;
                        sclk_d    = 1'b1;
                        sdata_d   = shreg_q[FRAME_BITS-1];
                        shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
                    end
                end
            end
            ST_GAP: begin
                if (tick_c) begin
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
`ifdef DAC_SPI_BUF_EN
                        // A start in this very cycle is newer than the buffer.
                        if (start) begin
                            launch_c  = 1'b1;
                            buf_vld_d = 1'b0;
                        end else if (buf_vld_q) begin
                            launch_c      = 1'b1;
                            launch_data_c = buf_q;
                            buf_vld_d     = 1'b0;
                        end
`endif
                        if (!launch_c) begin
                            state_d = ST_IDLE;
                            phase_d = 1'b0;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Load a new frame; bit 15 is presented immediately, the rest shifts.
        if (launch_c) begin
            frame_c   = build_frame(PD_MODE, launch_data_c);
            state_d   = ST_SHIFT;
            phase_d   = 1'b0;
            bit_cnt_d = BIT_CNT_W'(FRAME_BITS - 1);
            busy_d    = 1'b1;
            sync_n_d  = 1'b0;
            sclk_d    = 1'b1;
            sdata_d   = frame_c[FRAME_BITS-1];
            shreg_d   = {frame_c[FRAME_BITS-2:0], 1'b0};
        end

`ifdef DAC_SPI_BUF_EN
        if (start && busy_q && !gap_end_c) begin
            buf_d     = dato;
            buf_vld_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            phase_q   <= 1'b0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sync_n_q  <= 1'b1;
            sclk_q    <= 1'b1;
            sdata_q   <= 1'b0;
`ifdef DAC_SPI_BUF_EN
            buf_q     <= '0;
            buf_vld_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            sync_n_q  <= sync_n_d;
            sclk_q    <= sclk_d;
            sdata_q   <= sdata_d;
`ifdef DAC_SPI_BUF_EN
            buf_q     <= buf_d;
            buf_vld_q <= buf_vld_d;
`endif
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign sync_n = sync_n_q;
    assign sclk   = sclk_q;
    assign sdata  = sdata_q;

endmodule
